// File: rtl/replica_pkg.sv
// Shared types and default phase latencies for the replica-exchange annealing datapath.
package replica_pkg;

    typedef enum logic [1:0] {
        OPT_NONE    = 2'd0,
        OPT_TWO_OPT = 2'd1,
        OPT_OR_OPT  = 2'd2,
        OPT_SWAP    = 2'd3
    } opt_command_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RAND = 3'd1,
        DIST = 3'd2,
        MTR  = 3'd3,
        REPL = 3'd4,
        EXCH = 3'd5,
        DONE = 3'd6
    } anneal_state_t;

    localparam int DEF_RND_LAT  = 4;
    localparam int DEF_DIST_LAT = 8;
    localparam int DEF_MTR_LAT  = 6;
    localparam int DEF_REPL_LAT = 6;
    localparam int DEF_EX_LAT   = 32;
    localparam int TIMER_W      = 16;

    // A phase of lat cycles loads lat-1 and leaves when the timer hits zero.
    function automatic logic [TIMER_W-1:0] lat_load(input int lat);
        return TIMER_W'(lat - 1);
    endfunction

endpackage

// File: rtl/anneal_sequencer_phase_timer.sv
// Loadable down-counter with zero flag; one instance times every sequencer phase.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/anneal_sequencer.sv
// Annealing phase sequencer: RAND -> DIST -> MTR [-> REPL -> EXCH] per iteration.
// ANNEAL_BANK_TOGGLE_EN: exchange_bank flips on every EXCH exit; otherwise tied to 0.
//   state | meaning
//   IDLE  | waiting for start
//   RAND  | random draw phase
//   DIST  | delta-distance phase
//   MTR   | metropolis test phase
//   REPL  | replica exchange test
//   EXCH  | ordering / total-distance exchange
//   DONE  | one-cycle completion pulse
module anneal_sequencer
    import replica_pkg::*;
#(
    parameter int RND_LAT  = DEF_RND_LAT,
    parameter int DIST_LAT = DEF_DIST_LAT,
    parameter int MTR_LAT  = DEF_MTR_LAT,
    parameter int REPL_LAT = DEF_REPL_LAT,
    parameter int EX_LAT   = DEF_EX_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  iter_num,
    input  logic [7:0]   repl_interval,
    input  opt_command_t opt_sel,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output opt_command_t opt_command,
    output logic         random_run,
    output logic         distance_run,
    output logic         metropolis_run,
    output logic         replica_run,
    output logic         exchange_run,
    output logic         exchange_bank,
    output logic [31:0]  iter_cnt
);

    anneal_state_t state_q, state_d;
    logic [31:0]   iter_num_q, iter_num_d;
    logic [31:0]   iter_cnt_q, iter_cnt_d;
    logic [7:0]    repl_int_q, repl_int_d;
    logic [7:0]    repl_cnt_q, repl_cnt_d;
    opt_command_t  opt_q, opt_d;
    logic          tmr_load;
    logic [TIMER_W-1:0] tmr_val, tmr_cnt;
    logic          tmr_zero;
`ifdef ANNEAL_BANK_TOGGLE_EN
    logic          bank_q, bank_d;
`endif

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        iter_num_d = iter_num_q;
        iter_cnt_d = iter_cnt_q;
        repl_int_d = repl_int_q;
        repl_cnt_d = repl_cnt_q;
        opt_d      = opt_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef ANNEAL_BANK_TOGGLE_EN
        bank_d     = bank_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                iter_num_d = iter_num;
                repl_int_d = repl_interval;
                opt_d      = opt_sel;
                iter_cnt_d = '0;
                repl_cnt_d = '0;
`ifdef ANNEAL_BANK_TOGGLE_EN
                bank_d     = 1'b0;
`endif
                if (iter_num == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = RAND;
                    tmr_load = 1'b1;
                    tmr_val  = lat_load(RND_LAT);
                end
            end
        end else if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                RAND: if (tmr_zero) begin
                    state_d  = DIST;
                    tmr_load = 1'b1;
                    tmr_val  = lat_load(DIST_LAT);
                end
                DIST: if (tmr_zero) begin
                    state_d  = MTR;
                    tmr_load = 1'b1;
                    tmr_val  = lat_load(MTR_LAT);
                end
                MTR: if (tmr_zero) begin
                    if (repl_int_q != '0 && (repl_cnt_q + 8'd1) == repl_int_q) begin
                        repl_cnt_d = '0;
                        state_d    = REPL;
                        tmr_load   = 1'b1;
                        tmr_val    = lat_load(REPL_LAT);
                    end else begin
                        repl_cnt_d = repl_cnt_q + 8'd1;
                        iter_cnt_d = iter_cnt_q + 32'd1;
                    end
                end
                REPL: if (tmr_zero) begin
                    state_d  = EXCH;
                    tmr_load = 1'b1;
                    tmr_val  = lat_load(EX_LAT);
                end
                EXCH: if (tmr_zero) begin
                    iter_cnt_d = iter_cnt_q + 32'd1;
`ifdef ANNEAL_BANK_TOGGLE_EN
                    bank_d     = ~bank_q;
`endif
                end
                default: state_d = IDLE;
            endcase
            // Iteration boundary: either MTR without exchange or EXCH just finished.
            if (iter_cnt_d != iter_cnt_q) begin
                if (iter_cnt_d == iter_num_q) begin
                    state_d = DONE;
                end else begin
                    state_d  = RAND;
                    tmr_load = 1'b1;
                    tmr_val  = lat_load(RND_LAT);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            iter_num_q <= '0;
            iter_cnt_q <= '0;
            repl_int_q <= '0;
            repl_cnt_q <= '0;
            opt_q      <= OPT_NONE;
`ifdef ANNEAL_BANK_TOGGLE_EN
            bank_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            iter_num_q <= iter_num_d;
            iter_cnt_q <= iter_cnt_d;
            repl_int_q <= repl_int_d;
            repl_cnt_q <= repl_cnt_d;
            opt_q      <= opt_d;
`ifdef ANNEAL_BANK_TOGGLE_EN
            bank_q     <= bank_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign opt_command    = opt_q;
    assign iter_cnt       = iter_cnt_q;
    assign random_run     = (state_q == RAND) && (tmr_cnt == lat_load(RND_LAT));
    assign distance_run   = (state_q == DIST) && (tmr_cnt == lat_load(DIST_LAT));
    assign metropolis_run = (state_q == MTR)  && (tmr_cnt == lat_load(MTR_LAT));
    assign replica_run    = (state_q == REPL) && (tmr_cnt == lat_load(REPL_LAT));
    assign exchange_run   = (state_q == EXCH) && (tmr_cnt == lat_load(EX_LAT));
`ifdef ANNEAL_BANK_TOGGLE_EN
    assign exchange_bank  = bank_q;
`else
    assign exchange_bank  = 1'b0;
`endif

endmodule
